// File: rtl/risc_single_cycle_top.sv
// Single-cycle RV32I subset core (add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq, jal).
// Fixed program ROM and a data RAM that survives reset; one instruction commits per clk edge.
module risc_single_cycle_top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [31:0] PC, instruction, RD1, RD2, ImmExt, SrcA, SrcB;
  logic [31:0] ALUResult, ReadData, Result, x5, x6;
  logic [2:0]  ALUControl;

  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS] = '{default: '0};

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] pc_word, pc_plus4, pc_target, next_pc;
  logic [DAW-1:0] daddr;
  logic        reg_write, mem_write, alu_src_imm, is_branch, is_jal, is_load;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  // PC[1:0] is dropped here so misaligned jump targets still fetch a whole word
  assign pc_word = {2'b00, PC[31:2]} % IMEM_WORDS;

  always_comb begin
    case (pc_word)
      32'd0:   instruction = 32'h00500293;
      32'd1:   instruction = 32'h00700313;
      32'd2:   instruction = 32'h006283B3;
      32'd3:   instruction = 32'h40530433;
      32'd4:   instruction = 32'h00702023;
      32'd5:   instruction = 32'h00002483;
      32'd6:   instruction = 32'h00748463;
      32'd7:   instruction = 32'h00000293;
      32'd8:   instruction = 32'h00542333;
      32'd9:   instruction = 32'h0000006F;
      default: instruction = 32'h00000013;
    endcase
  end

  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    alu_src_imm = 1'b1;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    is_load     = 1'b0;
    ALUControl  = 3'b000;
    case (opcode)
      OP_R: begin
        alu_src_imm = 1'b0;
        reg_write   = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: ALUControl = 3'b000;
          {7'h20, 3'b000}: ALUControl = 3'b001;
          {7'h00, 3'b111}: ALUControl = 3'b010;
          {7'h00, 3'b110}: ALUControl = 3'b011;
          {7'h00, 3'b010}: ALUControl = 3'b101;
          default:         reg_write  = 1'b0;
        endcase
      end
      OP_I: begin
        reg_write = 1'b1;
        case (funct3)
          3'b000:  ALUControl = 3'b000;
          3'b111:  ALUControl = 3'b010;
          3'b110:  ALUControl = 3'b011;
          3'b010:  ALUControl = 3'b101;
          default: reg_write  = 1'b0;
        endcase
      end
      OP_LW: begin
        reg_write = 1'b1;
        is_load   = 1'b1;
      end
      OP_SW:  mem_write = 1'b1;
      OP_BEQ: begin
        alu_src_imm = 1'b0;
        is_branch   = 1'b1;
        ALUControl  = 3'b001;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        is_jal    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   ImmExt = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BEQ:  ImmExt = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
      OP_JAL:  ImmExt = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
      default: ImmExt = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

  assign RD1  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign RD2  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign SrcA = RD1;
  assign SrcB = alu_src_imm ? ImmExt : RD2;
  assign x5   = regs[5];
  assign x6   = regs[6];

  always_comb begin
    case (ALUControl)
      3'b001:  ALUResult = SrcA - SrcB;
      3'b010:  ALUResult = SrcA & SrcB;
      3'b011:  ALUResult = SrcA | SrcB;
      3'b101:  ALUResult = {31'd0, $signed(SrcA) < $signed(SrcB)};
      default: ALUResult = SrcA + SrcB;
    endcase
  end

  assign daddr    = DAW'({2'b00, ALUResult[31:2]} % DMEM_WORDS);
  assign ReadData = dmem[daddr];

  assign pc_plus4  = PC + 32'd4;
  assign pc_target = PC + ImmExt;
  assign next_pc   = (is_jal || (is_branch && ALUResult == 32'd0)) ? pc_target : pc_plus4;
  assign Result    = is_load ? ReadData : (is_jal ? pc_plus4 : ALUResult);

  always_ff @(posedge clk) begin
    if (rst) begin
      PC <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      PC <= next_pc;
      if (reg_write && rd != 5'd0) regs[rd] <= Result;
    end
  end

  // data RAM is deliberately outside the reset domain so stored words survive a restart
  always_ff @(posedge clk) begin
    if (!rst && mem_write) dmem[daddr] <= RD2;
  end
endmodule

// File: tb/tb_risc_single_cycle_top.sv
// Bench for risc_single_cycle_top: instruction-level model of the fixed program checked every
// cycle, plus hand-computed checkpoints.
module tb_risc_single_cycle_top;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic check_en = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  risc_single_cycle_top dut (.clk(clk), .rst(rst));

  typedef enum {ADDI, ADD, SUB, SW, LW, BEQ, SLT, JAL, NOP} op_e;
  op_e         p_op  [10];
  int          p_rd  [10];
  int          p_rs1 [10];
  int          p_rs2 [10];
  int          p_imm [10];
  logic [31:0] p_enc [10];

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];

  function automatic void set_i(int k, op_e op, int rd, int rs1, int rs2, int imm,
                                logic [31:0] enc);
    p_op[k] = op; p_rd[k] = rd; p_rs1[k] = rs1; p_rs2[k] = rs2; p_imm[k] = imm; p_enc[k] = enc;
  endfunction

  initial begin
    set_i(0, ADDI, 5, 0, 0, 5, 32'h00500293);
    set_i(1, ADDI, 6, 0, 0, 7, 32'h00700313);
    set_i(2, ADD,  7, 5, 6, 0, 32'h006283B3);
    set_i(3, SUB,  8, 6, 5, 0, 32'h40530433);
    set_i(4, SW,   0, 0, 7, 0, 32'h00702023);
    set_i(5, LW,   9, 0, 0, 0, 32'h00002483);
    set_i(6, BEQ,  0, 9, 7, 8, 32'h00748463);
    set_i(7, ADDI, 5, 0, 0, 0, 32'h00000293);
    set_i(8, SLT,  6, 8, 5, 0, 32'h00542333);
    set_i(9, JAL,  0, 0, 0, 0, 32'h0000006F);
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One architectural step of the current model instruction.
  function automatic void eval(output logic [31:0] enc, output logic [31:0] alu,
                               output logic [31:0] res, output logic [31:0] npc,
                               output int rd, output bit wr, output bit alu_ok,
                               output bit st, output int st_idx, output logic [31:0] st_data);
    int k;
    logic [31:0] a, b, imm;
    k = int'((m_pc >> 2) % 64);
    enc = 32'h00000013; alu = 32'd0; res = 32'd0; npc = m_pc + 32'd4;
    rd = 0; wr = 1'b0; alu_ok = 1'b0; st = 1'b0; st_idx = 0; st_data = 32'd0;
    if (k < 10) begin
      enc = p_enc[k];
      rd  = p_rd[k];
      a   = m_regs[p_rs1[k]];
      b   = m_regs[p_rs2[k]];
      imm = 32'(p_imm[k]);
      alu_ok = 1'b1;
      case (p_op[k])
        ADDI: begin alu = a + imm; res = alu; wr = 1'b1; end
        ADD:  begin alu = a + b;   res = alu; wr = 1'b1; end
        SUB:  begin alu = a - b;   res = alu; wr = 1'b1; end
        SLT:  begin alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; res = alu; wr = 1'b1; end
        SW: begin
          alu = a + imm; res = alu;
          st = 1'b1; st_idx = int'((alu >> 2) % 64); st_data = b;
        end
        LW: begin
          alu = a + imm; res = m_mem[int'((alu >> 2) % 64)]; wr = 1'b1;
        end
        BEQ: begin
          alu = a - b; res = alu;
          if (a == b) npc = m_pc + imm;
        end
        JAL: begin
          alu_ok = 1'b0; res = m_pc + 32'd4; npc = m_pc + imm; wr = 1'b1;
        end
        default: alu_ok = 1'b0;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    logic [31:0] enc, alu, res, npc, st_data;
    int rd, st_idx;
    bit wr, alu_ok, st;
    if (rst) begin
      m_pc <= 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else begin
      eval(enc, alu, res, npc, rd, wr, alu_ok, st, st_idx, st_data);
      if (st) m_mem[st_idx] <= st_data;
      if (wr && rd != 0) m_regs[rd] <= res;
      m_pc <= npc;
    end
  end

  always @(negedge clk) begin
    logic [31:0] enc, alu, res, npc, st_data;
    int rd, st_idx;
    bit wr, alu_ok, st;
    if (check_en) begin
      eval(enc, alu, res, npc, rd, wr, alu_ok, st, st_idx, st_data);
      check("model_pc", dut.PC, m_pc);
      check("model_instr", dut.instruction, enc);
      check("model_x5", dut.x5, m_regs[5]);
      check("model_x6", dut.x6, m_regs[6]);
      if (alu_ok) check("model_alu", dut.ALUResult, alu);
      if (wr) check("model_result", dut.Result, res);
    end
  end

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    check("rst_pc", dut.PC, 32'h0);
    check("rst_x5", dut.x5, 32'h0);
    check("rst_x6", dut.x6, 32'h0);
    check("rst_instr", dut.instruction, 32'h00500293);
    rst = 1'b0;

    edges(2);
    check("add_pc", dut.PC, 32'h08);
    check("add_x5", dut.x5, 32'd5);
    check("add_x6", dut.x6, 32'd7);
    check("add_srca", dut.SrcA, 32'd5);
    check("add_srcb", dut.SrcB, 32'd7);
    check("add_aluctl", 32'(dut.ALUControl), 32'd0);
    check("add_alu", dut.ALUResult, 32'd12);

    edges(3);
    check("lw_pc", dut.PC, 32'h14);
    check("lw_readdata", dut.ReadData, 32'd12);
    check("lw_result", dut.Result, 32'd12);

    edges(1);
    check("beq_pc", dut.PC, 32'h18);
    check("lw_x9", dut.regs[9], 32'd12);
    check("beq_aluctl", 32'(dut.ALUControl), 32'd1);
    check("beq_alu", dut.ALUResult, 32'd0);
    check("beq_imm", dut.ImmExt, 32'd8);

    edges(1);
    check("beq_target", dut.PC, 32'h20);
    check("skip_x5", dut.x5, 32'd5);
    check("slt_srcb", dut.SrcB, 32'd5);

    edges(1);
    check("jal_pc", dut.PC, 32'h24);
    check("slt_x6", dut.x6, 32'd1);
    check("jal_imm", dut.ImmExt, 32'd0);
    check("jal_result", dut.Result, 32'h28);

    edges(1);
    check("edge9_pc", dut.PC, 32'h24);
    check("edge9_x6", dut.x6, 32'd1);

    edges(5);
    check("loop_pc", dut.PC, 32'h24);
    check("loop_x5", dut.x5, 32'd5);
    check("loop_x6", dut.x6, 32'd1);
    check("loop_x7", dut.regs[7], 32'd12);
    check("loop_x8", dut.regs[8], 32'd2);
    check("loop_x9", dut.regs[9], 32'd12);

    rst = 1'b1;
    edges(1);
    check("rerst_pc", dut.PC, 32'h0);
    check("rerst_x5", dut.x5, 32'h0);
    check("rerst_x6", dut.x6, 32'h0);
    check("rerst_x7", dut.regs[7], 32'h0);
    check("rerst_mem0", dut.dmem[0], 32'd12);
    rst = 1'b0;

    edges(12);
    check("rerun_pc", dut.PC, 32'h24);
    check("rerun_x5", dut.x5, 32'd5);
    check("rerun_x6", dut.x6, 32'd1);
    check("rerun_mem0", dut.dmem[0], 32'd12);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
